bsg_credit_flow_sender: RTL and testbench
=========================================

# bsg_credit_flow_sender

Transmit-side credit counter that pairs with a receiver-side flow counter. It accepts items from a local producer on a valid/yumi handshake and forwards them over a registered valid-only channel. Each item spends one credit; the receiver returns one credit for each item it dequeues. The block sits in front of a link whose far end is a fixed-depth FIFO, so the sender can never overrun that FIFO.

## Interface
- `width_p`, default 8: data payload width in bits.
- `els_p`, default 64: far-end FIFO depth, which is also the initial credit count.
- Counter width: `$clog2(els_p+1)` bits (7 bits for the default).

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: reset, synchronous and active-high.
- `v_i`, in, 1: producer has a valid item.
- `data_i`, in, `width_p`: producer payload.
- `yumi_o`, out, 1: item consumed this cycle.
- `v_o`, out, 1: link valid, registered.
- `data_o`, out, `width_p`: link payload, registered.
- `credit_i`, in, 1: one credit returned by the receiver; at most one per cycle.
- `credit_count_o`, out, counter width: credits currently available.
- `error_o`, out, 1: sticky error; set when a credit is returned while the count is already full.

## Operation
- Credit register `credits_r`:
  - Reset value: `els_p`.
  - Next value: `credits_r - yumi_o + credit_i`, with these cases:
    - `yumi_o` and `credit_i` in the same cycle: unchanged.
    - `yumi_o` only: decrement by 1.
    - `credit_i` only: increment by 1.
  - Overflow: `credit_i=1` with `credits_r==els_p` and `yumi_o=0` is an error. `credits_r` holds at `els_p` (no wrap) and `error_o` sets.
  - When `credits_r==els_p` and `yumi_o=1` coincides with `credit_i=1`, the net change is 0. This is legal and raises no error.
- `yumi_o = v_i & (credits_r != 0) & ~reset_i`:
  - Combinational from `v_i`, following valid-then-yumi.
  - The producer must not make `v_i` depend on `yumi_o`.
- Credit exhaustion: with `credits_r==0`, `yumi_o=0`. A credit arriving in the same cycle is not bypassed and becomes usable next cycle.
- Output register:
  - On `yumi_o=1`, `data_o` loads `data_i` and `v_o` is 1 on the next cycle.
  - Otherwise `v_o` is 0 and `data_o` holds its last value.
  - The link has no backpressure; the credits guarantee space at the far end.
- `credit_count_o = credits_r`.
- Error flag: `error_o` is sticky and clears only on reset. Underflow cannot occur because `yumi_o` is gated by `credits_r != 0`.
- No state machine beyond the counter, the output register and the error flag.

## Timing
- Reset values:
  - `v_o=0`
  - `data_o=0`
  - `credit_count_o=els_p`
  - `error_o=0`
  - `yumi_o=0` while `reset_i=1`
- Latency:
  - Handshake at edge t (`yumi_o=1`) gives `v_o=1` with that data in cycle t+1.
  - `credit_count_o` reflects the handshake from cycle t+1.
- Credit return: `credit_i` at edge t raises `credit_count_o` in cycle t+1. `yumi_o` can use that credit from cycle t+1.
- Throughput: one item per cycle while credits remain. In steady state the round-trip credit loop sustains full rate whenever `els_p` covers the round-trip latency.
- Reset mid-operation:
  - Everything returns to reset values on the next edge.
  - An in-flight `v_o` is dropped.
  - Credits restore to `els_p` regardless of the current count.
  - Resetting both link ends together is a system requirement.

## Test plan
Bench uses `els_p=4`, `width_p=8`.
1. **Reset:** hold `reset_i` for 2 cycles with `v_i=1` -> `yumi_o=0` throughout, `credit_count_o=4`, `v_o=0`, `error_o=0`.
2. **Exhaustion:** `v_i=1` with data 0x10..0x15, `credit_i=0` -> `yumi_o=1` for exactly 4 cycles. `v_o` pulses carry 0x10..0x13, each 1 cycle after its handshake. Count falls 4→3→2→1→0, then `yumi_o=0`.
3. **No bypass:** at count 0 with `v_i=1`, pulse `credit_i` once -> `yumi_o=0` in the credit cycle and 1 in the next cycle. Count goes 0→1→0. `v_o=1` with data 0x14 one cycle after that handshake.
4. **Simultaneous events:** at count 2, `v_i=1` and `credit_i=1` for 5 cycles -> `yumi_o=1` every cycle, count stays 2, 5 consecutive `v_o` pulses.
5. **Overflow:** at count 4, `credit_i=1` with `v_i=0` -> count stays 4 and `error_o=1` next cycle. `error_o` remains 1 through further traffic until reset, then reads 0.
6. **Reset mid-stream:** at count 1 with `v_o=1`, assert `reset_i` for 1 cycle -> next cycle `v_o=0`, `credit_count_o=4`, `error_o=0`. Traffic resumes with full credits.

Source files
------------

// File: rtl/bsg_credit_flow_sender.sv
// bsg_credit_flow_sender
//
// Transmit side of a credit-based link. Items from a local producer are
// accepted on a valid/yumi handshake and forwarded on a registered,
// valid-only channel. Each forwarded item spends one credit. The far-end
// receiver returns one credit per item it dequeues, so the far-end FIFO
// (depth els_p) can never be overrun.
//
// Parameters:
//   width_p         payload width in bits
//   els_p           far-end FIFO depth; also the initial credit count
//
// Ports:
//   clk_i           clock
//   reset_i         synchronous, active-high reset
//   v_i             producer has a valid item
//   data_i          producer payload
//   yumi_o          item consumed this cycle (combinational from v_i)
//   v_o             link valid (registered)
//   data_o          link payload (registered, holds when v_o is low)
//   credit_i        one credit returned by the receiver (at most one per cycle)
//   credit_count_o  credits currently available
//   error_o         sticky: credit returned while the count was already full

module bsg_credit_flow_sender #(
   parameter int width_p = 8,
   parameter int els_p   = 64
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       v_i,
   input  logic [width_p-1:0]         data_i,
   output logic                       yumi_o,
   output logic                       v_o,
   output logic [width_p-1:0]         data_o,
   input  logic                       credit_i,
   output logic [$clog2(els_p+1)-1:0] credit_count_o,
   output logic                       error_o
);

   localparam int cnt_w_lp = $clog2(els_p + 1);

   localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);
   localparam logic [cnt_w_lp-1:0] one_lp  = cnt_w_lp'(1);

   logic [cnt_w_lp-1:0] credits_r;
   logic [cnt_w_lp-1:0] credits_n;
   logic                overflow;

   // A credit returned in the same cycle is deliberately not bypassed:
   // only registered credits gate the handshake, which keeps the
   // credit_i -> yumi_o path out of the producer's timing.
   always_comb begin
      yumi_o = v_i & (credits_r != '0) & ~reset_i;
   end

   // NOTE: every variable in this block gets a default before any branch,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      credits_n = credits_r;
      overflow  = 1'b0;
      if (yumi_o && !credit_i) begin
         credits_n = credits_r - one_lp;
      end else if (credit_i && !yumi_o) begin
         // A surplus credit at full count is a protocol error; saturate
         // instead of wrapping so the count stays meaningful.
         if (credits_r == full_lp) begin
            overflow = 1'b1;
         end else begin
            credits_n = credits_r + one_lp;
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         credits_r <= full_lp;
         v_o       <= 1'b0;
         data_o    <= '0;
         error_o   <= 1'b0;
      end else begin
         credits_r <= credits_n;
         v_o       <= yumi_o;
         if (yumi_o) begin
            data_o <= data_i;
         end
         if (overflow) begin
            error_o <= 1'b1;
         end
      end
   end

   assign credit_count_o = credits_r;

endmodule

// File: tb/tb_bsg_credit_flow_sender.sv
// Testbench for bsg_credit_flow_sender with els_p=4, width_p=8.
// Expected values come from a simple behavioural model: an integer credit
// count, the last forwarded item and an error bit.

module tb_bsg_credit_flow_sender;

   localparam int width_lp = 8;
   localparam int els_lp   = 4;
   localparam int cnt_w_lp = $clog2(els_lp + 1);

   logic                clk_i = 1'b0;
   logic                reset_i = 1'b1;
   logic                v_i = 1'b0;
   logic [width_lp-1:0] data_i = '0;
   logic                yumi_o;
   logic                v_o;
   logic [width_lp-1:0] data_o;
   logic                credit_i = 1'b0;
   logic [cnt_w_lp-1:0] credit_count_o;
   logic                error_o;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model
   int                  m_credits = els_lp;
   logic                m_v       = 1'b0;
   logic [width_lp-1:0] m_data    = '0;
   logic                m_err     = 1'b0;

   bsg_credit_flow_sender #(.width_p(width_lp), .els_p(els_lp)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .v_i            (v_i),
      .data_i         (data_i),
      .yumi_o         (yumi_o),
      .v_o            (v_o),
      .data_o         (data_o),
      .credit_i       (credit_i),
      .credit_count_o (credit_count_o),
      .error_o        (error_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic model_yumi();
      return v_i && (m_credits > 0) && !reset_i;
   endfunction

   // Apply inputs mid-cycle and settle before any comparisons.
   task automatic drive(input logic v, input logic [width_lp-1:0] d,
                        input logic c, input logic rst);
      @(negedge clk_i);
      v_i      = v;
      data_i   = d;
      credit_i = c;
      reset_i  = rst;
      #1;
   endtask

   // Advance one clock edge and update the model from the spec rules.
   task automatic tick();
      logic y;
      int   nc;
      y = model_yumi();
      @(posedge clk_i);
      if (reset_i) begin
         m_credits = els_lp;
         m_v       = 1'b0;
         m_data    = '0;
         m_err     = 1'b0;
      end else begin
         m_v = y;
         if (y) m_data = data_i;
         nc = m_credits - int'(y) + int'(credit_i);
         if (nc > els_lp) begin
            m_err = 1'b1;
            nc    = els_lp;
         end
         m_credits = nc;
      end
   endtask

   task automatic test_reset();
      drive(1'b1, 8'hA5, 1'b0, 1'b1);
      n_checks++;
      if (yumi_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_yumi_c0: got %b want 0", yumi_o);
      end
      tick();
      drive(1'b1, 8'h5A, 1'b0, 1'b1);
      n_checks++;
      if (yumi_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_yumi_c1: got %b want 0", yumi_o);
      end
      n_checks++;
      if (credit_count_o !== cnt_w_lp'(4)) begin
         n_fail++; $display("FAIL reset_count: got %0d want 4", credit_count_o);
      end
      n_checks++;
      if (v_o !== 1'b0 || data_o !== 8'h00) begin
         n_fail++; $display("FAIL reset_link: got v=%b d=%h want v=0 d=00", v_o, data_o);
      end
      n_checks++;
      if (error_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_error: got %b want 0", error_o);
      end
      tick();
   endtask

   task automatic test_exhaustion();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
         n_checks++;
         if (yumi_o !== (i < 4)) begin
            n_fail++; $display("FAIL exh_yumi[%0d]: got %b want %b", i, yumi_o, (i < 4));
         end
         n_checks++;
         if (credit_count_o !== cnt_w_lp'((i < 4) ? 4 - i : 0)) begin
            n_fail++; $display("FAIL exh_count[%0d]: got %0d want %0d", i, credit_count_o, (i < 4) ? 4 - i : 0);
         end
         n_checks++;
         if (v_o !== (i >= 1 && i <= 4) || (v_o && data_o !== 8'(8'h10 + i - 1))) begin
            n_fail++; $display("FAIL exh_link[%0d]: got v=%b d=%h want v=%b d=%h", i, v_o, data_o, (i >= 1 && i <= 4), 8'(8'h10 + i - 1));
         end
         tick();
      end
   endtask

   task automatic test_no_bypass();
      drive(1'b1, 8'h14, 1'b1, 1'b0);
      n_checks++;
      if (yumi_o !== 1'b0 || credit_count_o !== cnt_w_lp'(0)) begin
         n_fail++; $display("FAIL nobyp_credit_cycle: got yumi=%b cnt=%0d want yumi=0 cnt=0", yumi_o, credit_count_o);
      end
      tick();
      drive(1'b1, 8'h14, 1'b0, 1'b0);
      n_checks++;
      if (yumi_o !== 1'b1 || credit_count_o !== cnt_w_lp'(1)) begin
         n_fail++; $display("FAIL nobyp_next_cycle: got yumi=%b cnt=%0d want yumi=1 cnt=1", yumi_o, credit_count_o);
      end
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (credit_count_o !== cnt_w_lp'(0) || v_o !== 1'b1 || data_o !== 8'h14) begin
         n_fail++; $display("FAIL nobyp_after: got cnt=%0d v=%b d=%h want cnt=0 v=1 d=14", credit_count_o, v_o, data_o);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      logic [width_lp-1:0] prev;
      logic [width_lp-1:0] d;
      prev = 'x;
      // bring count from 0 to 2
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         drive(i < 5, d, i < 5, 1'b0);
         n_checks++;
         if (credit_count_o !== cnt_w_lp'(2) || (i < 5 && yumi_o !== 1'b1)) begin
            n_fail++; $display("FAIL simul_yumi_cnt[%0d]: got yumi=%b cnt=%0d want yumi=1 cnt=2", i, yumi_o, credit_count_o);
         end
         if (i > 0) begin
            n_checks++;
            if (v_o !== 1'b1 || data_o !== prev) begin
               n_fail++; $display("FAIL simul_link[%0d]: got v=%b d=%h want v=1 d=%h", i, v_o, data_o, prev);
            end
         end
         prev = d;
         tick();
      end
   endtask

   task automatic test_overflow();
      // count 2 -> 4
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (credit_count_o !== cnt_w_lp'(4) || error_o !== 1'b0) begin
         n_fail++; $display("FAIL ovf_before: got cnt=%0d err=%b want cnt=4 err=0", credit_count_o, error_o);
      end
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (credit_count_o !== cnt_w_lp'(4) || error_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_after: got cnt=%0d err=%b want cnt=4 err=1", credit_count_o, error_o);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'($urandom), 8'($urandom), (m_credits < els_lp) && 1'($urandom), 1'b0);
         n_checks++;
         if (error_o !== 1'b1 || credit_count_o !== cnt_w_lp'(m_credits)) begin
            n_fail++; $display("FAIL ovf_sticky[%0d]: got err=%b cnt=%0d want err=1 cnt=%0d", i, error_o, credit_count_o, m_credits);
         end
         tick();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (error_o !== 1'b0 || credit_count_o !== cnt_w_lp'(4)) begin
         n_fail++; $display("FAIL ovf_cleared: got err=%b cnt=%0d want err=0 cnt=4", error_o, credit_count_o);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 8'h33, 1'b0, 1'b1);
      n_checks++;
      if (credit_count_o !== cnt_w_lp'(1) || v_o !== 1'b1 || yumi_o !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_pre: got cnt=%0d v=%b yumi=%b want cnt=1 v=1 yumi=0", credit_count_o, v_o, yumi_o);
      end
      tick();
      drive(1'b1, 8'h40, 1'b0, 1'b0);
      n_checks++;
      if (v_o !== 1'b0 || credit_count_o !== cnt_w_lp'(4) || error_o !== 1'b0 || yumi_o !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_post: got v=%b cnt=%0d err=%b yumi=%b want v=0 cnt=4 err=0 yumi=1", v_o, credit_count_o, error_o, yumi_o);
      end
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (v_o !== 1'b1 || data_o !== 8'h40 || credit_count_o !== cnt_w_lp'(3)) begin
         n_fail++; $display("FAIL rstmid_resume: got v=%b d=%h cnt=%0d want v=1 d=40 cnt=3", v_o, data_o, credit_count_o);
      end
      tick();
   endtask

   // Random traffic with a well-behaved receiver: credits are only
   // returned while some are outstanding.
   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom), 8'($urandom), (m_credits < els_lp) && ($urandom_range(2) != 0), 1'b0);
         n_checks++;
         if (yumi_o !== model_yumi() || credit_count_o !== cnt_w_lp'(m_credits) ||
             v_o !== m_v || data_o !== m_data || error_o !== m_err) begin
            n_fail++;
            $display("FAIL random[%0d]: got yumi=%b cnt=%0d v=%b d=%h err=%b want yumi=%b cnt=%0d v=%b d=%h err=%b",
                     i, yumi_o, credit_count_o, v_o, data_o, error_o,
                     model_yumi(), m_credits, m_v, m_data, m_err);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_exhaustion();
      test_no_bypass();
      test_simultaneous();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
